// File: rtl/l2_cache_assoc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l2_cache_assoc                                                             |
// | Set-associative write-back, write-allocate L2 with beat-wise MM transfers. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module l2_cache_assoc #(
    parameter int n          = 32,
    parameter int block_size = 16,
    parameter int addr_w     = 15,
    parameter int sets       = 64,
    parameter int ways       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MM_busy,
    input  logic [addr_w-1:0] L1_word_address,
    input  logic [n-1:0]      L1_wdata,
    input  logic              L1_write_request,
    input  logic              L1_read_request,
    input  logic [n-1:0]      MM_read_word,
    output logic [n-1:0]      L1_rdata,
    output logic [addr_w-1:0] MM_word_address,
    output logic [n-1:0]      MM_write_word,
    output logic              MM_read_request,
    output logic              MM_write_request,
    output logic              L2_busy,
    output logic              flush,
    output logic [31:0]       hit_counter,
    output logic [31:0]       miss_counter
);
    localparam int c_OW = $clog2(block_size);
    localparam int c_IW = $clog2(sets);
    localparam int c_TW = addr_w - c_IW - c_OW;
    localparam int c_WB = (ways > 1) ? $clog2(ways) : 1;
    localparam logic [c_WB-1:0] c_AGE_MAX   = c_WB'(ways - 1);
    localparam logic [c_OW-1:0] c_LAST_BEAT = c_OW'(block_size - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_COMPARE   = 2'd1;
    localparam logic [1:0] c_WRITEBACK = 2'd2;
    localparam logic [1:0] c_ALLOCATE  = 2'd3;

    logic [n-1:0]      r_data  [ways][sets*block_size];
    logic [c_TW-1:0]   r_tag   [ways][sets];
    logic [c_WB-1:0]   r_age   [ways][sets];
    logic [ways-1:0]   r_valid [sets];
    logic [ways-1:0]   r_dirty [sets];

    logic [1:0]        r_state;
    logic [addr_w-1:0] r_addr;
    logic [n-1:0]      r_wdata;
    logic              r_write;
    logic [c_OW-1:0]   r_beat;
    logic [c_WB-1:0]   r_victim;
    logic              r_refilled;

    logic [c_TW-1:0]   w_tag;
    logic [c_IW-1:0]   w_index;
    logic [c_OW-1:0]   w_offset;
    logic              w_hit;
    logic [c_WB-1:0]   w_hit_way;
    logic              w_any_invalid;
    logic [c_WB-1:0]   w_inv_way;
    logic [c_WB-1:0]   w_old_way;
    logic [c_WB-1:0]   w_old_age;
    logic [c_WB-1:0]   w_victim;
    logic [c_WB-1:0]   w_next_victim;
    logic [1:0]        w_next_state;
    logic [c_OW-1:0]   w_next_beat;
    logic              w_req;

    assign {w_tag, w_index, w_offset} = r_addr;
    assign w_req = L1_write_request | L1_read_request;

    // Hit lookup and victim choice: lowest invalid way, else oldest (lowest on ties)
    always_comb begin
        w_hit         = 1'b0;
        w_hit_way     = '0;
        w_any_invalid = 1'b0;
        w_inv_way     = '0;
        w_old_way     = '0;
        w_old_age     = '0;
        for (int w = 0; w < ways; w++) begin
            if (!w_hit && r_valid[w_index][c_WB'(w)] && (r_tag[c_WB'(w)][w_index] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WB'(w);
            end
            if (!w_any_invalid && !r_valid[w_index][c_WB'(w)]) begin
                w_any_invalid = 1'b1;
                w_inv_way     = c_WB'(w);
            end
            if (r_age[c_WB'(w)][w_index] > w_old_age) begin
                w_old_age = r_age[c_WB'(w)][w_index];
                w_old_way = c_WB'(w);
            end
        end
        w_victim      = w_any_invalid ? w_inv_way : w_old_way;
        w_next_victim = (r_state == c_COMPARE) ? w_victim : r_victim;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_beat  = r_beat;
        case (r_state)
            c_IDLE: begin
                if (w_req) w_next_state = c_COMPARE;
            end
            c_COMPARE: begin
                if (w_hit)
                    w_next_state = c_IDLE;
                else if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim])
                    w_next_state = c_WRITEBACK;
                else
                    w_next_state = c_ALLOCATE;
            end
            c_WRITEBACK: begin
                if (!MM_busy) begin
                    if (r_beat == c_LAST_BEAT) begin
                        w_next_state = c_ALLOCATE;
                        w_next_beat  = '0;
                    end else begin
                        w_next_beat = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                if (!MM_busy) begin
                    if (r_beat == c_LAST_BEAT) begin
                        w_next_state = c_COMPARE;
                        w_next_beat  = '0;
                    end else begin
                        w_next_beat = r_beat + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_beat           <= '0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_write          <= 1'b0;
            r_victim         <= '0;
            r_refilled       <= 1'b0;
            L1_rdata         <= '0;
            MM_word_address  <= '0;
            MM_write_word    <= '0;
            MM_read_request  <= 1'b0;
            MM_write_request <= 1'b0;
            L2_busy          <= 1'b0;
            flush            <= 1'b0;
            hit_counter      <= '0;
            miss_counter     <= '0;
            for (int s = 0; s < sets; s++) begin
                r_valid[c_IW'(s)] <= '0;
                r_dirty[c_IW'(s)] <= '0;
                for (int w = 0; w < ways; w++) r_age[c_WB'(w)][c_IW'(s)] <= '0;
            end
        end else begin
            r_state          <= w_next_state;
            r_beat           <= w_next_beat;
            L2_busy          <= (w_next_state != c_IDLE);
            flush            <= 1'b0;
            MM_write_request <= (w_next_state == c_WRITEBACK);
            MM_read_request  <= (w_next_state == c_ALLOCATE);
            // Outputs are registered, so they are loaded with the values for the coming beat
            if (w_next_state == c_WRITEBACK) begin
                MM_word_address <= {r_tag[w_next_victim][w_index], w_index, w_next_beat};
                MM_write_word   <= r_data[w_next_victim][{w_index, w_next_beat}];
            end else if (w_next_state == c_ALLOCATE) begin
                MM_word_address <= {w_tag, w_index, w_next_beat};
            end

            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_addr     <= L1_word_address;
                        r_wdata    <= L1_wdata;
                        r_write    <= L1_write_request;
                        r_refilled <= 1'b0;
                    end
                end
                c_COMPARE: begin
                    if (w_hit) begin
                        if (r_write) begin
                            r_data[w_hit_way][{w_index, w_offset}] <= r_wdata;
                            r_dirty[w_index][w_hit_way]            <= 1'b1;
                        end else begin
                            L1_rdata <= r_data[w_hit_way][{w_index, w_offset}];
                        end
                        for (int w = 0; w < ways; w++) begin
                            if (c_WB'(w) == w_hit_way)
                                r_age[c_WB'(w)][w_index] <= '0;
                            else if (r_age[c_WB'(w)][w_index] != c_AGE_MAX)
                                r_age[c_WB'(w)][w_index] <= r_age[c_WB'(w)][w_index] + 1'b1;
                        end
                        if (!r_refilled && (hit_counter != '1)) hit_counter <= hit_counter + 32'd1;
                        r_refilled <= 1'b0;
                    end else begin
                        if (miss_counter != '1) miss_counter <= miss_counter + 32'd1;
                        r_victim <= w_victim;
                        flush    <= r_valid[w_index][w_victim];
                    end
                end
                c_WRITEBACK: begin
                    if (!MM_busy && (r_beat == c_LAST_BEAT)) r_dirty[w_index][r_victim] <= 1'b0;
                end
                default: begin
                    if (!MM_busy) begin
                        r_data[r_victim][{w_index, r_beat}] <= MM_read_word;
                        if (r_beat == c_LAST_BEAT) begin
                            r_valid[w_index][r_victim] <= 1'b1;
                            r_dirty[w_index][r_victim] <= 1'b0;
                            r_tag[r_victim][w_index]   <= w_tag;
                            r_refilled                 <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_cache_assoc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_l2_cache_assoc                                                          |
// | Directed bench with a transaction-level cache/memory model.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_l2_cache_assoc;
    logic        clk = 1'b0;
    logic        reset;
    logic        MM_busy;
    logic [14:0] L1_word_address;
    logic [31:0] L1_wdata;
    logic        L1_write_request;
    logic        L1_read_request;
    logic [31:0] MM_read_word;
    logic [31:0] L1_rdata;
    logic [14:0] MM_word_address;
    logic [31:0] MM_write_word;
    logic        MM_read_request;
    logic        MM_write_request;
    logic        L2_busy;
    logic        flush;
    logic [31:0] hit_counter;
    logic [31:0] miss_counter;

    l2_cache_assoc #(.n(32), .block_size(16), .addr_w(15), .sets(64), .ways(2)) dut (
        .clk(clk), .reset(reset), .MM_busy(MM_busy),
        .L1_word_address(L1_word_address), .L1_wdata(L1_wdata),
        .L1_write_request(L1_write_request), .L1_read_request(L1_read_request),
        .MM_read_word(MM_read_word), .L1_rdata(L1_rdata),
        .MM_word_address(MM_word_address), .MM_write_word(MM_write_word),
        .MM_read_request(MM_read_request), .MM_write_request(MM_write_request),
        .L2_busy(L2_busy), .flush(flush),
        .hit_counter(hit_counter), .miss_counter(miss_counter)
    );

    always #5 clk = ~clk;

    // Main memory: contents start as 5*(word offset within block)
    logic [31:0] mem [0:32767];
    assign MM_read_word = mem[MM_word_address];

    // Cache model: ways=2, 64 sets, 16-word blocks
    bit          m_valid [2][64];
    bit          m_dirty [2][64];
    int          m_tag   [2][64];
    int          m_age   [2][64];
    logic [31:0] m_data  [2][64][16];
    longint      m_hits, m_misses;

    int checks = 0;
    int failures = 0;

    int          rd_q[$];
    int          wb_addr_q[$];
    logic [31:0] wb_data_q[$];
    int          rd_log[$];
    int          wb_addr_log[$];
    logic [31:0] wb_data_log[$];
    int          busy_addr_log[$];
    int          rd_accepted, rd_req_cycles, flush_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++) begin
                m_valid[w][s] = 0; m_dirty[w][s] = 0; m_age[w][s] = 0;
            end
        m_hits = 0; m_misses = 0;
    endtask

    // Per-cycle comparison of the memory-side outputs against the expected beat streams
    always @(negedge clk) begin
        if (!reset) begin
            check("mm_req_exclusive", 64'(MM_read_request & MM_write_request), 64'd0);
            if (!L2_busy) check("mm_req_when_idle", 64'(MM_read_request | MM_write_request), 64'd0);
            if (flush) flush_cnt++;
            if (MM_write_request) begin
                if (wb_addr_q.size() == 0) check("wb_unexpected", 64'(wb_addr_q.size()), 64'd1);
                else begin
                    check("wb_addr", 64'(MM_word_address), 64'(wb_addr_q[0]));
                    check("wb_data", 64'(MM_write_word), 64'(wb_data_q[0]));
                    if (!MM_busy) begin
                        wb_addr_log.push_back(int'(MM_word_address));
                        wb_data_log.push_back(MM_write_word);
                        wb_addr_q.delete(0);
                        wb_data_q.delete(0);
                    end
                end
            end
            if (MM_read_request) begin
                rd_req_cycles++;
                if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_q.size()), 64'd1);
                else begin
                    check("rd_addr", 64'(MM_word_address), 64'(rd_q[0]));
                    if (MM_busy) busy_addr_log.push_back(int'(MM_word_address));
                    else begin
                        rd_log.push_back(int'(MM_word_address));
                        rd_q.delete(0);
                        rd_accepted++;
                    end
                end
            end
        end
    end

    // One L1 transaction: predict with the model, drive, then compare the outcome
    task automatic access(input int a, input logic [31:0] d, input bit wr, input bit rd,
                          input int stall_beat, input int stall_len, input int rst_beat);
        int idx, tg, off, way, exp_cycles, cycles, stalls_done, exp_flush;
        bit hit, wb, aborted;
        logic [31:0] exp_rdata;
        idx = (a >> 4) % 64; tg = a >> 10; off = a % 16;
        rd_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
        rd_log.delete(); wb_addr_log.delete(); wb_data_log.delete(); busy_addr_log.delete();
        rd_accepted = 0; rd_req_cycles = 0; flush_cnt = 0;
        hit = 0; wb = 0; way = 0; exp_flush = 0; exp_rdata = '0;
        for (int w = 0; w < 2; w++)
            if (!hit && m_valid[w][idx] && m_tag[w][idx] == tg) begin hit = 1; way = w; end
        if (hit) begin
            if (m_hits < 64'hFFFF_FFFF) m_hits++;
        end else begin
            if (m_misses < 64'hFFFF_FFFF) m_misses++;
            way = -1;
            for (int w = 0; w < 2; w++) if (way < 0 && !m_valid[w][idx]) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < 2; w++) if (m_age[w][idx] > m_age[way][idx]) way = w;
            end
            exp_flush = m_valid[way][idx] ? 1 : 0;
            if (m_valid[way][idx] && m_dirty[way][idx]) begin
                wb = 1;
                for (int b = 0; b < 16; b++) begin
                    wb_addr_q.push_back(m_tag[way][idx] * 1024 + idx * 16 + b);
                    wb_data_q.push_back(m_data[way][idx][b]);
                    mem[m_tag[way][idx] * 1024 + idx * 16 + b] = m_data[way][idx][b];
                end
            end
            for (int b = 0; b < 16; b++) begin
                rd_q.push_back(tg * 1024 + idx * 16 + b);
                m_data[way][idx][b] = mem[tg * 1024 + idx * 16 + b];
            end
            m_valid[way][idx] = 1; m_tag[way][idx] = tg; m_dirty[way][idx] = 0;
        end
        if (wr) begin
            m_data[way][idx][off] = d; m_dirty[way][idx] = 1;
        end else exp_rdata = m_data[way][idx][off];
        for (int w = 0; w < 2; w++)
            if (w == way) m_age[w][idx] = 0;
            else if (m_age[w][idx] < 1) m_age[w][idx]++;
        exp_cycles = hit ? 1 : 18 + (wb ? 16 : 0) + stall_len;

        L1_word_address = 15'(a); L1_wdata = d;
        L1_write_request = wr; L1_read_request = rd;
        @(posedge clk); #1;
        cycles = 0; stalls_done = 0; aborted = 0;
        while (L2_busy && cycles < 200) begin
            if (rst_beat >= 0 && MM_read_request && rd_accepted == rst_beat) begin
                reset = 1; L1_write_request = 0; L1_read_request = 0;
                @(posedge clk); #1;
                check("rst_l2_busy", 64'(L2_busy), 64'd0);
                check("rst_mm_read_request", 64'(MM_read_request), 64'd0);
                check("rst_mm_write_request", 64'(MM_write_request), 64'd0);
                check("rst_hit_counter", 64'(hit_counter), 64'd0);
                check("rst_miss_counter", 64'(miss_counter), 64'd0);
                reset = 0; model_reset();
                rd_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
                aborted = 1;
                break;
            end
            if (MM_read_request && rd_accepted == stall_beat && stalls_done < stall_len) begin
                MM_busy = 1; stalls_done++;
            end else MM_busy = 0;
            @(posedge clk); #1;
            cycles++;
        end
        L1_write_request = 0; L1_read_request = 0; MM_busy = 0;
        if (!aborted) begin
            check("busy_cycles", 64'(cycles), 64'(exp_cycles));
            if (!wr) check("l1_rdata", 64'(L1_rdata), 64'(exp_rdata));
            check("hit_counter", 64'(hit_counter), 64'(m_hits));
            check("miss_counter", 64'(miss_counter), 64'(m_misses));
            check("flush_pulses", 64'(flush_cnt), 64'(exp_flush));
            check("rd_beats_left", 64'(rd_q.size()), 64'd0);
            check("wb_beats_left", 64'(wb_addr_q.size()), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'(5 * (i % 16));
        model_reset();
        reset = 1; MM_busy = 0; L1_word_address = '0; L1_wdata = '0;
        L1_write_request = 0; L1_read_request = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("reset_l2_busy", 64'(L2_busy), 64'd0);
        check("reset_hits", 64'(hit_counter), 64'd0);
        check("reset_misses", 64'(miss_counter), 64'd0);
        check("reset_mm_rd", 64'(MM_read_request), 64'd0);
        check("reset_mm_wr", 64'(MM_write_request), 64'd0);
        check("reset_flush", 64'(flush), 64'd0);
        check("reset_rdata", 64'(L1_rdata), 64'd0);
        check("reset_mm_addr", 64'(MM_word_address), 64'd0);

        // Cold write allocate
        access(1000, 32'd8, 1, 0, -1, 0, -1);
        check("cold_miss_count", 64'(miss_counter), 64'd1);
        check("cold_hit_count", 64'(hit_counter), 64'd0);
        check("cold_rd_cycles", 64'(rd_req_cycles), 64'd16);
        check("cold_first_addr", 64'(rd_log[0]), 64'd992);
        check("cold_last_addr", 64'(rd_log[15]), 64'd1007);

        access(1000, 32'd0, 0, 1, -1, 0, -1);
        check("hit_rdata_lit", 64'(L1_rdata), 64'd8);
        check("hit_count_lit", 64'(hit_counter), 64'd1);
        access(1001, 32'd0, 0, 1, -1, 0, -1);
        check("hit_refill_word_lit", 64'(L1_rdata), 64'd45);

        // Refill with a two-cycle stall at beat 5
        access(5000, 32'd0, 0, 1, 5, 2, -1);
        check("stall_rd_cycles", 64'(rd_req_cycles), 64'd18);
        check("stall_hold_n", 64'(busy_addr_log.size()), 64'd2);
        check("stall_hold_addr0", 64'(busy_addr_log[0]), 64'd4997);
        check("stall_hold_addr1", 64'(busy_addr_log[1]), 64'd4997);
        check("stall_rdata_lit", 64'(L1_rdata), 64'd40);

        // Fill the second way of set 62, then force eviction of the dirty 992 block
        access(2024, 32'h22, 1, 0, -1, 0, -1);
        access(3048, 32'd0, 0, 1, -1, 0, -1);
        check("evict_flush_lit", 64'(flush_cnt), 64'd1);
        check("evict_wb_n", 64'(wb_addr_log.size()), 64'd16);
        check("evict_wb_first", 64'(wb_addr_log[0]), 64'd992);
        check("evict_wb_last", 64'(wb_addr_log[15]), 64'd1007);
        check("evict_wb_word8", 64'(wb_data_log[8]), 64'd8);
        check("evict_wb_word9", 64'(wb_data_log[9]), 64'd45);
        check("evict_refill_first", 64'(rd_log[0]), 64'd3040);
        check("evict_rdata_lit", 64'(L1_rdata), 64'd40);
        access(2024, 32'd0, 0, 1, -1, 0, -1);
        check("lru_protected_lit", 64'(L1_rdata), 64'h22);

        // Simultaneous read and write: the write wins
        access(1000, 32'd3, 1, 1, -1, 0, -1);
        access(1000, 32'd0, 0, 1, -1, 0, -1);
        check("rw_both_lit", 64'(L1_rdata), 64'd3);

        // Reset in the middle of a refill, then the old line must miss
        access(6000, 32'd0, 0, 1, -1, 0, 7);
        access(1000, 32'd0, 0, 1, -1, 0, -1);
        check("post_reset_miss_lit", 64'(miss_counter), 64'd1);
        check("post_reset_hits_lit", 64'(hit_counter), 64'd0);
        check("post_reset_rdata_lit", 64'(L1_rdata), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
